// File: rtl/lieat_exu_oitf.sv
// Outstanding Instruction Track FIFO: records in-flight long-latency
// instructions (LSU, MUL/DIV). It reports RAW/WAW hazards against their
// destination registers and retires entries on long writeback reports.

`ifndef RGIDX_SIZE
`define RGIDX_SIZE 5
`endif

module lieat_exu_oitf #(
    parameter int OITF_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    // dispatch / allocation
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic                   disp_unit,
    input  logic                   disp_rden,
    input  logic [`RGIDX_SIZE-1:0] disp_rd,
    // dependency check for the dispatching instruction
    input  logic                   dep_rs1en,
    input  logic [`RGIDX_SIZE-1:0] dep_rs1,
    input  logic                   dep_rs2en,
    input  logic [`RGIDX_SIZE-1:0] dep_rs2,
    input  logic                   dep_rden,
    input  logic [`RGIDX_SIZE-1:0] dep_rd,
    output logic                   oitf_raw_dep,
    output logic                   disp_waw_dep,
    // common-path writeback WAW check
    input  logic                   com_rden,
    input  logic [`RGIDX_SIZE-1:0] com_rd,
    output logic                   oitf_waw_dep,
    // long writeback report
    input  logic                   longi_wbck,
    input  logic [1:0]             longi_wbck_op,
    // status
    output logic                   oitf_empty,
    output logic                   oitf_err
);

    localparam int RG_W = `RGIDX_SIZE;

    // Per-entry state
    logic [OITF_DEPTH-1:0]           vld_q, vld_d;
    logic [OITF_DEPTH-1:0]           unit_q;
    logic [OITF_DEPTH-1:0]           rden_q;
    logic [OITF_DEPTH-1:0][RG_W-1:0] rd_q;

    // Pointers and sticky error
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             err_q, err_d;

    // Retire search results
    logic             alloc;
    logic             ret_fire;
    logic             ret_hit;
    logic [PTR_W-1:0] ret_idx;
    logic             head_hit;
    logic [PTR_W-1:0] scan_idx;

    // Per-entry dependency hits
    logic [OITF_DEPTH-1:0] raw_hit;
    logic [OITF_DEPTH-1:0] dwaw_hit;
    logic [OITF_DEPTH-1:0] cwaw_hit;

    // Ready depends only on registered state: the slot at wptr must be free
    assign disp_ready = ~vld_q[wptr_q];
    assign alloc      = disp_valid & disp_ready;
    // op 00/01 retire a unit; 1x is "none" or reserved
    assign ret_fire   = longi_wbck & ~longi_wbck_op[1];

    // Retire target, next-state valid vector, pointer and error update
    always_comb begin
        ret_hit  = 1'b0;
        ret_idx  = '0;
        head_hit = 1'b0;
        scan_idx = '0;
        vld_d    = vld_q;
        wptr_d   = wptr_q + {{(PTR_W-1){1'b0}}, alloc};
        err_d    = err_q;

        // Oldest valid entry of the reported unit, walking in age order from the head
        for (int k = 0; k < OITF_DEPTH; k++) begin
            scan_idx = rptr_q + PTR_W'(k);
            if (!ret_hit && vld_q[scan_idx] && (unit_q[scan_idx] == longi_wbck_op[0])) begin
                ret_hit = 1'b1;
                ret_idx = scan_idx;
            end
        end

        if (ret_fire && ret_hit) begin
            vld_d[ret_idx] = 1'b0;
        end
        if (ret_fire && !ret_hit) begin
            err_d = 1'b1;
        end
        // Allocation slot is known free, so it never collides with the retire slot
        if (alloc) begin
            vld_d[wptr_q] = 1'b1;
        end

        // New head: oldest entry still valid after this cycle, else catch up to wptr
        rptr_d = wptr_d;
        for (int k = 0; k < OITF_DEPTH; k++) begin
            scan_idx = rptr_q + PTR_W'(k);
            if (!head_hit && vld_d[scan_idx]) begin
                head_hit = 1'b1;
                rptr_d   = scan_idx;
            end
        end
    end

    // State registers; reset discards every entry at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= '0;
            unit_q <= '0;
            rden_q <= '0;
            rd_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            err_q  <= err_d;
            if (alloc) begin
                unit_q[wptr_q] <= disp_unit;
                rden_q[wptr_q] <= disp_rden;
                rd_q[wptr_q]   <= disp_rd;
            end
        end
    end

    // Dependency compares against registered entries only; entries without rd never match
    generate
        for (genvar gi = 0; gi < OITF_DEPTH; gi++) begin : g_dep
            logic live;
            assign live         = vld_q[gi] & rden_q[gi];
            assign raw_hit[gi]  = live & ((dep_rs1en & (rd_q[gi] == dep_rs1)) |
                                          (dep_rs2en & (rd_q[gi] == dep_rs2)));
            assign dwaw_hit[gi] = live & dep_rden & (rd_q[gi] == dep_rd);
            assign cwaw_hit[gi] = live & com_rden & (rd_q[gi] == com_rd);
        end
    endgenerate

    assign oitf_raw_dep = |raw_hit;
    assign disp_waw_dep = |dwaw_hit;
    assign oitf_waw_dep = |cwaw_hit;
    assign oitf_empty   = ~|vld_q;
    assign oitf_err     = err_q;

endmodule
